// File: rtl/alu_issue_sched.sv
// Issue scheduler: round-robin pick of one ready requester per cycle, S1 issue register
// driving a shared combinational ALU, S2 result register presented to the CDB via valid/ready.
// Optional macro ALU_SCHED_BRANCH_PRIO_EN: branch ops (opcode 1100011) win arbitration over non-branch.
module alu_issue_sched #(
    parameter int NUM_REQ       = 4,
    parameter int OPRAND_WIDTH  = 32,
    parameter int OP_FUNC_WIDTH = 17,
    parameter int TAG_WIDTH     = 6
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*OP_FUNC_WIDTH-1:0]   req_op_func_i,
    input  logic [NUM_REQ*OPRAND_WIDTH-1:0]    req_oprand1_i,
    input  logic [NUM_REQ*OPRAND_WIDTH-1:0]    req_oprand2_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]       req_tag_i,
    output logic [NUM_REQ-1:0]                 req_grant_o,
    output logic [OP_FUNC_WIDTH-1:0]           alu_op_func_o,
    output logic [OPRAND_WIDTH-1:0]            alu_oprand1_o,
    output logic [OPRAND_WIDTH-1:0]            alu_oprand2_o,
    input  logic [OPRAND_WIDTH-1:0]            alu_result_i,
    output logic                               cdb_valid_o,
    input  logic                               cdb_ready_i,
    output logic [TAG_WIDTH-1:0]               cdb_tag_o,
    output logic [OPRAND_WIDTH-1:0]            cdb_result_o,
    output logic                               busy_o
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic                     s1_valid, s2_valid;
    logic [OP_FUNC_WIDTH-1:0] s1_op;
    logic [OPRAND_WIDTH-1:0]  s1_a, s1_b;
    logic [TAG_WIDTH-1:0]     s1_tag;
    logic [PTR_W-1:0]         rr_ptr, grant_idx;
    logic [PTR_W:0]           idx;
    logic                     s2_stall, s1_adv, grant_en, found, do_grant;
    logic [NUM_REQ-1:0]       cand;

    assign s2_stall = s2_valid & ~cdb_ready_i;
    assign s1_adv   = ~s2_stall;
    assign grant_en = ~s1_valid | s1_adv;

`ifdef ALU_SCHED_BRANCH_PRIO_EN
    logic [NUM_REQ-1:0] is_branch;
    always_comb begin
        is_branch = '0;
        for (int i = 0; i < NUM_REQ; i++)
            is_branch[i] = req_valid_i[i] && (req_op_func_i[i*OP_FUNC_WIDTH +: 7] == 7'b1100011);
        cand = (|is_branch) ? is_branch : req_valid_i;
    end
`else
    assign cand = req_valid_i;
`endif

    // Rotating search starting at rr_ptr; first candidate found wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (idx >= (PTR_W+1)'(NUM_REQ))
                idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!found && cand[idx[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    assign do_grant = found & grant_en & ~flush_i & ~rst_i;

    always_comb begin
        req_grant_o = '0;
        if (do_grant)
            req_grant_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            rr_ptr       <= '0;
            s1_op        <= '0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_tag       <= '0;
            cdb_tag_o    <= '0;
            cdb_result_o <= '0;
        end else if (flush_i) begin
            // In-flight work (including a result being accepted this edge) is discarded.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (do_grant) begin
                rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                s1_valid <= 1'b1;
                s1_op    <= req_op_func_i[int'(grant_idx)*OP_FUNC_WIDTH +: OP_FUNC_WIDTH];
                s1_a     <= req_oprand1_i[int'(grant_idx)*OPRAND_WIDTH +: OPRAND_WIDTH];
                s1_b     <= req_oprand2_i[int'(grant_idx)*OPRAND_WIDTH +: OPRAND_WIDTH];
                s1_tag   <= req_tag_i[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_valid && s1_adv) begin
                s2_valid     <= 1'b1;
                cdb_result_o <= alu_result_i;
                cdb_tag_o    <= s1_tag;
            end else if (s2_valid && cdb_ready_i) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign alu_op_func_o = s1_valid ? s1_op : '0;
    assign alu_oprand1_o = s1_valid ? s1_a  : '0;
    assign alu_oprand2_o = s1_valid ? s1_b  : '0;
    assign cdb_valid_o   = s2_valid;
    assign busy_o        = s1_valid | s2_valid;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: expected CDB results are queued at grant time and
// checked by an independent monitor on each CDB handshake.
module tb_alu_issue_sched;
    localparam logic [16:0] OP_ADD = {7'b0000000, 3'b000, 7'b0110011};
    localparam logic [16:0] OP_SUB = {7'b0100000, 3'b000, 7'b0110011};
    localparam logic [16:0] OP_BEQ = {7'b0000000, 3'b000, 7'b1100011};

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, cdb_ready;
    logic [3:0]  req_valid;
    logic [67:0] req_op_func;
    logic [127:0] req_oprand1, req_oprand2;
    logic [23:0] req_tag;
    logic [3:0]  req_grant;
    logic [16:0] alu_op_func;
    logic [31:0] alu_oprand1, alu_oprand2, alu_result;
    logic        cdb_valid, busy;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_result;

    exp_t        expq[$];
    logic [5:0]  etag[4];
    logic [31:0] eres[4];
    int          n_cmp = 0;
    int          n_bad = 0;

    alu_issue_sched dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_op_func_i(req_op_func),
        .req_oprand1_i(req_oprand1), .req_oprand2_i(req_oprand2), .req_tag_i(req_tag),
        .req_grant_o(req_grant),
        .alu_op_func_o(alu_op_func), .alu_oprand1_o(alu_oprand1), .alu_oprand2_o(alu_oprand2),
        .alu_result_i(alu_result),
        .cdb_valid_o(cdb_valid), .cdb_ready_i(cdb_ready),
        .cdb_tag_o(cdb_tag), .cdb_result_o(cdb_result), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // External ALU stand-in: ADD/SUB by funct7[5], BEQ returns equality flag.
    always_comb begin
        if (alu_op_func[6:0] == 7'b1100011)
            alu_result = {31'b0, alu_oprand1 == alu_oprand2};
        else if (alu_op_func[15])
            alu_result = alu_oprand1 - alu_oprand2;
        else
            alu_result = alu_oprand1 + alu_oprand2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [16:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag, input logic [31:0] res);
        req_valid[i]            = 1'b1;
        req_op_func[i*17 +: 17] = op;
        req_oprand1[i*32 +: 32] = a;
        req_oprand2[i*32 +: 32] = b;
        req_tag[i*6 +: 6]       = tag;
        etag[i]                 = tag;
        eres[i]                 = res;
    endtask

    // One cycle: check the grant (g<0 means none), queue the expected result, drop the granted entry.
    task automatic step(input int g);
        logic [3:0] want;
        want = (g < 0) ? 4'b0 : 4'(1 << g);
        @(negedge clk);
        chk("grant", 32'(req_grant), 32'(want));
        if (g >= 0) expq.push_back('{etag[g], eres[g]});
        @(posedge clk); #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    // Monitor: every CDB handshake not cancelled by flush must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && cdb_valid && cdb_ready && !flush) begin
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL cdb_unexpected: got tag %0d res %0h, expected none", cdb_tag, cdb_result);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (cdb_tag !== e.tag || cdb_result !== e.res) begin
                    n_bad++;
                    $display("FAIL cdb_result: got tag %0d res %0h, expected tag %0d res %0h",
                             cdb_tag, cdb_result, e.tag, e.res);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
        req_valid = '0; req_op_func = '0; req_oprand1 = '0; req_oprand2 = '0; req_tag = '0;

        // Reset state
        @(negedge clk);
        chk("rst_cdb_valid", 32'(cdb_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(req_grant), 0);
        chk("rst_alu_op", 32'(alu_op_func), 0);
        chk("rst_cdb_tag", 32'(cdb_tag), 0);
        chk("rst_cdb_result", cdb_result, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single ADD: grant cycle 0, ALU inputs cycle 1, CDB cycle 2
        load(0, OP_ADD, 5, 7, 3, 12);
        step(0);
        @(negedge clk);
        chk("t2_alu_op1", alu_oprand1, 5);
        chk("t2_alu_op2", alu_oprand2, 7);
        chk("t2_alu_func", 32'(alu_op_func), 32'(OP_ADD));
        chk("t2_cdb_valid_c1", 32'(cdb_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_cdb_valid_c2", 32'(cdb_valid), 1);
        chk("t2_alu_idle", alu_oprand1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_busy_done", 32'(busy), 0);
        @(posedge clk); #1;

        // Reset mid-stream with S1 and S2 both occupied
        cdb_ready = 1'b0;
        load(1, OP_ADD, 1, 2, 10, 3);
        load(2, OP_SUB, 10, 4, 11, 6);
        step(1);
        step(2);
        load(3, OP_ADD, 100, 23, 13, 123);
        #2 rst = 1'b1;
        #1;
        chk("t1_cdb_valid", 32'(cdb_valid), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_grant", 32'(req_grant), 0);
        chk("t1_alu_op1", alu_oprand1, 0);
        expq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cdb_ready = 1'b1;

        // All requesters valid: grants 0,1,2,3,0 from a freshly reset pointer
        load(0, OP_ADD, 32'hFFFF_FFFF, 1, 20, 0);
        load(1, OP_SUB, 3, 5, 21, 32'hFFFF_FFFE);
        load(2, OP_ADD, 1000, 24, 22, 1024);
        step(0);
        load(0, OP_ADD, 2, 2, 24, 4);
        step(1);
        step(2);
        step(3);
        step(0);
        @(negedge clk);
        chk("t3_cdb_streaming", 32'(cdb_valid), 1);
        @(posedge clk); #1;
        step(-1);
        step(-1);
        chk("t3_busy_drained", 32'(busy), 0);

        // Backpressure: CDB not ready for 3 cycles with S1/S2 full
        load(1, OP_ADD, 7, 8, 30, 15);
        load(2, OP_ADD, 9, 9, 31, 18);
        load(3, OP_SUB, 50, 8, 32, 42);
        step(1);
        step(2);
        cdb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_stall_grant", 32'(req_grant), 0);
            chk("t4_stall_valid", 32'(cdb_valid), 1);
            chk("t4_stall_tag", 32'(cdb_tag), 30);
            chk("t4_stall_result", cdb_result, 15);
            chk("t4_s1_held", alu_oprand1, 9);
            @(posedge clk); #1;
        end
        cdb_ready = 1'b1;
        step(3);
        step(-1);
        step(-1);
        step(-1);
        chk("t4_busy_drained", 32'(busy), 0);

        // Flush with both stages full and all requesters valid
        load(0, OP_ADD, 1, 1, 40, 2);
        load(1, OP_ADD, 2, 2, 41, 4);
        step(0);
        step(1);
        load(0, OP_ADD, 3, 3, 42, 6);
        load(1, OP_ADD, 4, 4, 43, 8);
        load(2, OP_ADD, 5, 5, 44, 10);
        load(3, OP_ADD, 6, 6, 45, 12);
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_grant", 32'(req_grant), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        expq.delete();
        #1;
        chk("t5_cdb_valid", 32'(cdb_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_alu_zero", alu_oprand1, 0);
        step(2);
        step(3);
        step(0);
        step(1);
        step(-1);
        step(-1);
        step(-1);
        chk("t5_busy_drained", 32'(busy), 0);

        // Branch vs non-branch arbitration from rr_ptr=0
        load(3, OP_ADD, 0, 0, 50, 0);
        step(3);
        load(0, OP_ADD, 11, 22, 51, 33);
        load(2, OP_BEQ, 9, 9, 52, 1);
`ifdef ALU_SCHED_BRANCH_PRIO_EN
        step(2);
        step(0);
`else
        step(0);
        step(2);
`endif
        load(1, OP_BEQ, 3, 4, 53, 0);
        step(1);
        step(-1);
        step(-1);
        step(-1);
        chk("t6_busy_drained", 32'(busy), 0);

        for (int c = 0; c < 20 && expq.size() != 0; c++) @(posedge clk);
        chk("final_queue_empty", 32'(expq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
